// File: rtl/shift_pkg.sv
// Shared types for the barrel-shifter command path: direction encoding
// and the command bundle {data, amt, dir} for the default 3-stage shifter.
package shift_pkg;

    localparam int SP_NUM_STAGE = 3;
    localparam int SP_W         = 1 << SP_NUM_STAGE;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ASL = 2'b11
    } shift_dir_e;

    typedef struct packed {
        logic [SP_W-1:0]         data;
        logic [SP_NUM_STAGE-1:0] amt;
        shift_dir_e              dir;
    } shift_cmd_t;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Generic synchronous FIFO with internal occupancy count and full/empty flags.
// Ports: clk, rst_n, i_push/i_wdata (write), i_pop/o_rdata (head), o_full, o_empty.
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Writes while full are dropped; the caller gates on o_full anyway.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/shift_cmd_issue.sv
// Command FIFO in front of a combinational barrel shifter plus a registered,
// back-pressurable result slot. Ports: in_* command handshake, sh_* shifter
// drive/return, out_* result handshake. Optional: SHIFT_CMD_ISSUE_CNT_EN adds
// a 16-bit issue_cnt counting loads into the result slot.
module shift_cmd_issue
    import shift_pkg::*;
#(
    parameter int NUM_STAGE = 3,
    parameter int DEPTH     = 4,
    localparam int W        = 1 << NUM_STAGE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [NUM_STAGE-1:0] in_amt,
    input  logic [1:0]           in_dir,
    output logic [NUM_STAGE-1:0] sh_cntrl,
    output logic [W-1:0]         sh_data,
    output logic [1:0]           sh_dir,
    input  logic [W-1:0]         sh_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [1:0]           out_dir,
    output logic [NUM_STAGE-1:0] out_amt
`ifdef SHIFT_CMD_ISSUE_CNT_EN
    ,
    output logic [15:0]          issue_cnt
`endif
);

    typedef struct packed {
        logic [W-1:0]         data;
        logic [NUM_STAGE-1:0] amt;
        shift_dir_e           dir;
    } cmd_t;

    cmd_t                 w_wr_cmd;
    cmd_t                 w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_load;
    logic                 r_in_en;
    logic                 r_out_valid;
    logic [W-1:0]         r_out_data;
    logic [1:0]           r_out_dir;
    logic [NUM_STAGE-1:0] r_out_amt;

    // r_in_en keeps in_ready low until the first edge after reset release.
    assign in_ready = r_in_en && !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_load   = !w_empty && (!r_out_valid || out_ready);

    assign w_wr_cmd.data = in_data;
    assign w_wr_cmd.amt  = in_amt;
    assign w_wr_cmd.dir  = shift_dir_e'(in_dir);

    shift_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wr_cmd),
        .i_pop   (w_load),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head contents are stale when empty, so the shifter sees zeros instead.
    always_comb begin
        sh_cntrl = '0;
        sh_data  = '0;
        sh_dir   = '0;
        if (!w_empty) begin
            sh_cntrl = w_head.amt;
            sh_data  = w_head.data;
            sh_dir   = w_head.dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_en     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_dir   <= '0;
            r_out_amt   <= '0;
        end else begin
            r_in_en <= 1'b1;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= sh_result;
                r_out_dir   <= w_head.dir;
                r_out_amt   <= w_head.amt;
            end else if (out_ready) begin
                // No load with out_ready high implies the FIFO is empty.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_dir   = r_out_dir;
    assign out_amt   = r_out_amt;

`ifdef SHIFT_CMD_ISSUE_CNT_EN
    logic [15:0] r_issue_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= '0;
        end else if (w_load) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign issue_cnt = r_issue_cnt;
`endif

endmodule

// File: doc/shift_cmd_issue.md
Name: shift_cmd_issue

Overview:
- Upstream and downstream wrapper stage for the combinational multi-stage barrel shifter.
- Accepts shift commands (data, amount, direction) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives the shifter's per-stage control vector, data and direction from the FIFO head.
- Registers the shifter's result into an output stage with its own valid/ready handshake. This gives the combinational shifter a registered, back-pressurable pipeline slot.

Parameters:
- NUM_STAGE, 3: number of shifter stages. Data width W = 2**NUM_STAGE, amount width = NUM_STAGE.
- DEPTH, 4: command FIFO entries. Power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  command accepted when in_valid && in_ready at the clock edge.
- in_data  in  W  operand.
- in_amt  in  NUM_STAGE  shift amount 0..W-1.
- in_dir  in  2  00 LSL, 01 LSR, 10 ASR, 11 ASL.
- sh_cntrl  out  NUM_STAGE  to shifter. Bit i enables the shift-by-2^i stage.
- sh_data  out  W  to shifter.
- sh_dir  out  2  to shifter.
- sh_result  in  W  combinational result returned by the shifter.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  W  registered shift result.
- out_dir  out  2  direction of the held result.
- out_amt  out  NUM_STAGE  amount of the held result.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO count=0, rd/wr pointers=0, out_valid=0, out_data=0, out_dir=0, out_amt=0. in_ready is 0 while rst_n is low and 1 from the first edge after release.
- in_ready = !full, where full means count==DEPTH. No write bypass when full, even if a pop occurs in the same cycle.
- Push: on the in handshake, write {in_data, in_amt, in_dir} at wr_ptr, then wr_ptr++. Pointers wrap modulo DEPTH.
- Shifter drive (combinational from FIFO head):
  - sh_cntrl = head.amt, sh_data = head.data, sh_dir = head.dir.
  - When the FIFO is empty, all sh_* outputs are 0.
- Load condition: load = !empty && (!out_valid || out_ready).
- On load:
  - out_data <= sh_result, out_dir <= head.dir, out_amt <= head.amt, out_valid <= 1.
  - Pop the head (rd_ptr++).
- If out_valid && out_ready && empty, then out_valid <= 0. Output registers keep their last value.
- Count update:
  - count += push − pop.
  - A simultaneous push and pop leaves count unchanged.
  - Push into an empty FIFO is never bypassed to the output.
- Latency: a command accepted at edge k appears with out_valid=1 after edge k+1, provided the output slot is free. Throughput is 1 command/cycle with out_ready held high.
- Capacity: DEPTH+1 commands in flight (FIFO plus output register).
- Output stability: out_data, out_dir and out_amt stay stable while out_valid && !out_ready.
- in_amt=0 passes in_data unchanged for every direction.
- ASL result equals LSL result.
- Reset asserted mid-operation discards all queued and held commands immediately. No partial result is emitted after release.

Optional Feature:
- Macro: SHIFT_CMD_ISSUE_CNT_EN.
- Enabled:
  - Adds output port issue_cnt, 16 bits.
  - Increments on every load and wraps FFFF→0000.
  - Reset value 0.
- Disabled: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package shift_pkg:
  - shift_dir_e enum (LSL=2'b00, LSR=2'b01, ASR=2'b10, ASL=2'b11).
  - shift_cmd_t packed struct parameterised via NUM_STAGE-derived localparams {data, amt, dir}.
- Sub-module shift_cmd_fifo: generic synchronous FIFO with count and full/empty flags.
- The top level holds the output register, load/pop logic and optional counter.

Test Plan (NUM_STAGE=3, W=8, DEPTH=4; bench ties sh_result to a signed-aware reference shifter model):
- Reset release, push 8'hB4 amt=3 dir=00, out_ready=1 → out_valid high one cycle after accept, out_data=8'hA0, out_amt=3.
- Back-to-back 8'hB4 amt=3 with dir 01, 10, 11 → out_data 8'h16, 8'hF6, 8'hA0 on consecutive cycles, in_ready held 1.
- out_ready=0, push continuously → exactly 5 commands accepted, then in_ready=0. Raise out_ready → results drain in order, one per cycle, in_ready returns 1 after the first drain.
- Full FIFO with a simultaneous pop and in_valid → new command not accepted that cycle, accepted the next cycle. Order preserved.
- amt=0 with data 8'h81 in all dirs → out_data=8'h81. Empty FIFO → sh_cntrl=0, sh_data=0, sh_dir=0.
- Assert rst_n low with 3 queued and out_valid=1 → out_valid=0 immediately. After release, no stale result is emitted. With SHIFT_CMD_ISSUE_CNT_EN defined, issue_cnt=0 after reset and equals the number of loads afterwards.
